vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; replaces the fixed 640x480 generator.

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 raster constants, sync polarity encodings,
//             the control vector carried down the display delay line and a
//             helper that sums active/porch/sync widths into a total.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // 640x480@60 with a 100 MHz system clock divided down to 25 MHz
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 2;
    localparam int DEF_CW         = 10;

    // Level driven on a sync line while the pulse is asserted
    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Per-pixel control flags decoded from the counters and delayed to the
    // display side: syncs (already polarity-encoded), display enable,
    // h==0, v==0 and vertical blanking.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic h0;
        logic v0;
        logic vb;
    } vga_ctl_t;

    // Total period of one axis in pixels or lines
    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : vga_delay_line
//  Purpose  : Enable-gated shift register of DEPTH stages, WIDTH bits wide,
//             asynchronous active-low reset to RST_VAL. DEPTH=0 is a wire.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH   = 6,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = ^{clk, reset_n, shift_i};
        assign q_o      = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Advance every stage by one position on each shift request
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (shift_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Divides the system
//             clock into a pixel strobe, runs H/V counters, exposes the
//             undelayed fetch position and presents sync/display/blanking
//             flags PIPE_DELAY pixels later so memory latency is hidden.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_POL      = POL_ACTIVE_LOW,
    parameter bit V_POL      = POL_ACTIVE_LOW,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          pix_stb,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          fetch_valid,
    output logic          h_sync,
    output logic          v_sync,
    output logic          display,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Flags seen on the display side before the first real pixel arrives
    localparam vga_ctl_t CTL_IDLE = vga_ctl_t'({~H_POL, ~V_POL, 4'b0000});

    if (H_TOTAL > (1 << CW)) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_chk_pd
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic [DW-1:0] div_q, div_d;
    logic          run_q;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    vga_ctl_t      ctl_next_w, ctl_tail_w;
    logic          hs_q, vs_q, de_q, vb_q, ls_q, fs_q;

    // run_q keeps the strobe quiet during the first clock after reset,
    // which only matters when CLK_DIV=1 and the divider is always terminal.
    assign pix_stb = en && run_q && (div_q == DIV_LAST);

    // Divider and raster counter next-state
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        if (pix_stb) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    // Decoding the position being loaded lets the stages plus the output
    // register add up to exactly PIPE_DELAY pixels of latency.
    assign ctl_next_w.hs = ((h_d >= HS_BEG) && (h_d < HS_END)) ? H_POL : ~H_POL;
    assign ctl_next_w.vs = ((v_d >= VS_BEG) && (v_d < VS_END)) ? V_POL : ~V_POL;
    assign ctl_next_w.de = (h_d < H_ACT) && (v_d < V_ACT);
    assign ctl_next_w.h0 = (h_d == '0);
    assign ctl_next_w.v0 = (v_d == '0);
    assign ctl_next_w.vb = (v_d >= V_ACT);

    // Divider and raster counter state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            run_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            run_q <= 1'b1;
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (CTL_IDLE)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .shift_i (pix_stb),
        .d_i     (ctl_next_w),
        .q_o     (ctl_tail_w)
    );

    // Display-side output registers; pulses are held while paused so a
    // pulse interrupted by en=0 is still seen for exactly one enabled clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q <= CTL_IDLE.hs;
            vs_q <= CTL_IDLE.vs;
            de_q <= 1'b0;
            vb_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (en) begin
            if (pix_stb) begin
                hs_q <= ctl_tail_w.hs;
                vs_q <= ctl_tail_w.vs;
                de_q <= ctl_tail_w.de;
                vb_q <= ctl_tail_w.vb;
            end
            ls_q <= pix_stb && ctl_tail_w.h0;
            fs_q <= pix_stb && ctl_tail_w.h0 && ctl_tail_w.v0;
        end
    end

    assign fetch_x     = h_q;
    assign fetch_y     = v_q;
    assign fetch_valid = (h_q < H_ACT) && (v_q < V_ACT);
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign display     = de_q;
    assign vblank      = vb_q;
    assign line_start  = ls_q && en;
    assign frame_start = fs_q && en;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Three instances:
//             default 640x480, a small CLK_DIV=1 active-high-sync raster with
//             no pipeline delay, and a small CLK_DIV=3 raster with a 3-pixel
//             delay. Expected outputs come from raster arithmetic on strobe
//             counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int N = 3;
    localparam int P_DIV [N] = '{4, 1, 3};
    localparam int P_HA  [N] = '{640, 20, 12};
    localparam int P_HF  [N] = '{16, 3, 2};
    localparam int P_HS  [N] = '{96, 4, 3};
    localparam int P_HB  [N] = '{48, 5, 3};
    localparam int P_VA  [N] = '{480, 10, 6};
    localparam int P_VF  [N] = '{10, 2, 1};
    localparam int P_VS  [N] = '{2, 2, 2};
    localparam int P_VB  [N] = '{33, 3, 1};
    localparam bit P_HP  [N] = '{1'b0, 1'b1, 1'b0};
    localparam bit P_VP  [N] = '{1'b0, 1'b1, 1'b0};
    localparam int P_PD  [N] = '{2, 0, 3};
    localparam int P_CW  [N] = '{10, 6, 5};

    logic        clk = 1'b0;
    logic        rstn_r [N];
    logic        en_r   [N];
    logic [7:0]  fl_w   [N];   // {pix_stb, fetch_valid, h_sync, v_sync, display, line_start, frame_start, vblank}
    logic [31:0] fx_w   [N];
    logic [31:0] fy_w   [N];

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: clocks and enabled clocks since reset release, strobes
    // seen, and pending pulses awaiting their enabled clock
    int clk_c [N];
    int en_c  [N];
    int stb_c [N];
    bit ls_p  [N];
    bit fs_p  [N];
    bit last_hs [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [P_CW[g]-1:0] fx, fy;
        logic stb, fv, hs, vs, de, ls, fs, vb;
        vga_timing_gen #(
            .CLK_DIV    (P_DIV[g]),
            .H_ACTIVE   (P_HA[g]),
            .H_FP       (P_HF[g]),
            .H_SYNC     (P_HS[g]),
            .H_BP       (P_HB[g]),
            .V_ACTIVE   (P_VA[g]),
            .V_FP       (P_VF[g]),
            .V_SYNC     (P_VS[g]),
            .V_BP       (P_VB[g]),
            .H_POL      (P_HP[g]),
            .V_POL      (P_VP[g]),
            .PIPE_DELAY (P_PD[g]),
            .CW         (P_CW[g])
        ) u_dut (
            .clk         (clk),
            .reset_n     (rstn_r[g]),
            .en          (en_r[g]),
            .pix_stb     (stb),
            .fetch_x     (fx),
            .fetch_y     (fy),
            .fetch_valid (fv),
            .h_sync      (hs),
            .v_sync      (vs),
            .display     (de),
            .line_start  (ls),
            .frame_start (fs),
            .vblank      (vb)
        );
        assign fl_w[g] = {stb, fv, hs, vs, de, ls, fs, vb};
        assign fx_w[g] = 32'(fx);
        assign fy_w[g] = 32'(fy);
    end

    // Flags {hs,vs,de,h0,v0,vb} of the raster position reached after k
    // strobes; k<1 means nothing has reached the display side yet.
    function automatic logic [5:0] ctl_at(input int d, input int k);
        int ht, vt, h, v, hsb, vsb;
        logic [5:0] r;
        ht  = P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
        vt  = P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d];
        hsb = P_HA[d] + P_HF[d];
        vsb = P_VA[d] + P_VF[d];
        if (k < 1) begin
            r = {~P_HP[d], ~P_VP[d], 4'b0000};
        end else begin
            h = k % ht;
            v = (k / ht) % vt;
            r[5] = (h >= hsb && h < hsb + P_HS[d]) ? P_HP[d] : ~P_HP[d];
            r[4] = (v >= vsb && v < vsb + P_VS[d]) ? P_VP[d] : ~P_VP[d];
            r[3] = (h < P_HA[d]) && (v < P_VA[d]);
            r[2] = (h == 0);
            r[1] = (v == 0);
            r[0] = (v >= P_VA[d]);
        end
        return r;
    endfunction

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL d%0d %s: observed %0h expected %0h", d, tag, obs, exp_v);
        end
    endtask

    // One system clock on instance d: drive en/reset at the falling edge,
    // check all outputs, then advance the reference at the rising edge.
    task automatic cyc(input int d, input bit en_v, input bit rst_v);
        int ht, vt, h, v;
        logic [5:0] c;
        bit stb_e;
        @(negedge clk);
        en_r[d]   = en_v;
        rstn_r[d] = !rst_v;
        if (rst_v) begin
            clk_c[d] = 0; en_c[d] = 0; stb_c[d] = 0; ls_p[d] = 1'b0; fs_p[d] = 1'b0;
        end
        #1;
        ht = P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
        vt = P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d];
        h  = stb_c[d] % ht;
        v  = (stb_c[d] / ht) % vt;
        if (P_DIV[d] == 1) stb_e = en_v && (clk_c[d] >= 1);
        else               stb_e = en_v && ((en_c[d] % P_DIV[d]) == P_DIV[d] - 1);
        c = ctl_at(d, stb_c[d] - P_PD[d]);
        chk(d, "pix_stb",     32'(fl_w[d][7]), 32'(stb_e));
        chk(d, "fetch_x",     fx_w[d],         32'(h));
        chk(d, "fetch_y",     fy_w[d],         32'(v));
        chk(d, "fetch_valid", 32'(fl_w[d][6]), 32'((h < P_HA[d]) && (v < P_VA[d])));
        chk(d, "h_sync",      32'(fl_w[d][5]), 32'(c[5]));
        chk(d, "v_sync",      32'(fl_w[d][4]), 32'(c[4]));
        chk(d, "display",     32'(fl_w[d][3]), 32'(c[3]));
        chk(d, "line_start",  32'(fl_w[d][2]), 32'(en_v && ls_p[d]));
        chk(d, "frame_start", 32'(fl_w[d][1]), 32'(en_v && fs_p[d]));
        chk(d, "vblank",      32'(fl_w[d][0]), 32'(c[0]));
        last_hs[d] = fl_w[d][5];
        @(posedge clk);
        if (!rst_v) begin
            clk_c[d]++;
            if (en_v) en_c[d]++;
            if (stb_e) begin
                stb_c[d]++;
                c = ctl_at(d, stb_c[d] - P_PD[d]);
                ls_p[d] = c[2];
                fs_p[d] = c[2] && c[1];
            end else if (en_v) begin
                ls_p[d] = 1'b0;
                fs_p[d] = 1'b0;
            end
        end
    endtask

    // Reset, random-enable run with a 37-clock pause mid-run, reset pulse
    // while h_sync is asserted, then a second random run.
    task automatic test_dut(input int d, input int n1, input int n2);
        bit found;
        repeat (3) cyc(d, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < n1; i++) begin
            if (i == n1 / 2) repeat (37) cyc(d, 1'b0, 1'b0);
            cyc(d, $urandom_range(0, 15) != 0, 1'b0);
        end
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            cyc(d, 1'b1, 1'b0);
            found = (last_hs[d] == P_HP[d]);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL d%0d sync_seek: observed h_sync never asserted, expected asserted within 4000 clks", d);
        end
        repeat (2) cyc(d, 1'b1, 1'b1);
        for (int i = 0; i < n2; i++) cyc(d, $urandom_range(0, 15) != 0, 1'b0);
        cyc(d, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rstn_r[i] = 1'b0;
            en_r[i]   = 1'b0;
            clk_c[i]  = 0;
            en_c[i]   = 0;
            stb_c[i]  = 0;
            ls_p[i]   = 1'b0;
            fs_p[i]   = 1'b0;
            last_hs[i] = 1'b0;
        end
        test_dut(0, 10000, 3500);
        test_dut(1, 3000, 1500);
        test_dut(2, 4000, 1500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
